// File: rtl/arrow_key_decoder.sv
// Decodes PS/2 set-2 bytes into held/active arrow-key state for the car controller.
// Optional WASD_EN macro maps the W/S/A/D letter keys onto the same four key bits.
module arrow_key_decoder #(
   parameter int unsigned PREFIX_TIMEOUT = 650000
) (
   input  logic       pclk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [3:0] key,
   output logic [3:0] held,
   output logic       key_event
);

   localparam int unsigned CNT_W = $clog2(PREFIX_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_EXT_BRK = 2'd2,
      S_BRK     = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       key_q, key_d;
   logic [3:0]       held_q, held_d;
   logic             key_event_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       make_s;
   logic [3:0]       brk_s;

   function automatic logic [3:0] arrow_bit(input logic [7:0] code);
      logic [3:0] b;
      case (code)
         8'h75:   b = 4'b0001;
         8'h72:   b = 4'b0010;
         8'h6B:   b = 4'b0100;
         8'h74:   b = 4'b1000;
         default: b = 4'b0000;
      endcase
      return b;
   endfunction

`ifdef WASD_EN
   function automatic logic [3:0] wasd_bit(input logic [7:0] code);
      logic [3:0] b;
      case (code)
         8'h1D:   b = 4'b0001;
         8'h1B:   b = 4'b0010;
         8'h1C:   b = 4'b0100;
         8'h23:   b = 4'b1000;
         default: b = 4'b0000;
      endcase
      return b;
   endfunction
`endif

   // UP > DOWN > LEFT > RIGHT; result is always one-hot or zero
   function automatic logic [3:0] pick_priority(input logic [3:0] h);
      logic [3:0] b;
      if (h[0]) begin
         b = 4'b0001;
      end else if (h[1]) begin
         b = 4'b0010;
      end else if (h[2]) begin
         b = 4'b0100;
      end else if (h[3]) begin
         b = 4'b1000;
      end else begin
         b = 4'b0000;
      end
      return b;
   endfunction

   // Next-state decode: prefix FSM, timeout counter, and make/break effects
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      make_s  = 4'b0000;
      brk_s   = 4'b0000;

      if (rx_valid) begin
         cnt_d = '0;
         case (state_q)
            S_IDLE: begin
               if (rx_data == CODE_EXT) begin
                  state_d = S_EXT;
               end else if (rx_data == CODE_BRK) begin
                  state_d = S_BRK;
               end else begin
                  state_d = S_IDLE;
`ifdef WASD_EN
                  make_s  = wasd_bit(rx_data);
`else
                  make_s  = 4'b0000;
`endif
               end
            end
            S_EXT: begin
               if (rx_data == CODE_BRK) begin
                  state_d = S_EXT_BRK;
               end else if (rx_data == CODE_EXT) begin
                  state_d = S_EXT;
               end else begin
                  state_d = S_IDLE;
                  make_s  = arrow_bit(rx_data);
               end
            end
            S_EXT_BRK: begin
               if (rx_data == CODE_EXT) begin
                  state_d = S_EXT;
               end else if (rx_data == CODE_BRK) begin
                  state_d = S_EXT_BRK;
               end else begin
                  state_d = S_IDLE;
                  brk_s   = arrow_bit(rx_data);
               end
            end
            S_BRK: begin
               if (rx_data == CODE_EXT) begin
                  state_d = S_EXT;
               end else if (rx_data == CODE_BRK) begin
                  state_d = S_BRK;
               end else begin
                  state_d = S_IDLE;
`ifdef WASD_EN
                  brk_s   = wasd_bit(rx_data);
`else
                  brk_s   = 4'b0000;
`endif
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end else if (state_q != S_IDLE) begin
         // A byte arriving on the last cycle takes the branch above instead
         if (cnt_q >= CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         cnt_d = cnt_q;
      end

      if (make_s != 4'b0000) begin
         held_d = held_q | make_s;
         key_d  = make_s;
      end else if (brk_s != 4'b0000) begin
         held_d = held_q & ~brk_s;
         if (key_q == brk_s) begin
            key_d = pick_priority(held_q & ~brk_s);
         end else begin
            key_d = key_q;
         end
      end else begin
         held_d = held_q;
         key_d  = key_q;
      end
   end

   // State, key bitmaps and the one-cycle change pulse
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         key_q       <= 4'b0000;
         held_q      <= 4'b0000;
         key_event_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         held_q      <= held_d;
         key_event_q <= (key_d != key_q);
         cnt_q       <= cnt_d;
      end
   end

   assign key       = key_q;
   assign held      = held_q;
   assign key_event = key_event_q;

endmodule

// File: tb/tb_arrow_key_decoder.sv
// Directed, table-driven bench for arrow_key_decoder with a short prefix timeout.
module tb_arrow_key_decoder;

   logic       pclk;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [3:0] key;
   logic [3:0] held;
   logic       key_event;

   int n_cmp;
   int n_err;

   typedef struct {
      string       name;
      int unsigned nb;
      logic [31:0] bytes;
      logic [3:0]  exp_key;
      logic [3:0]  exp_held;
      logic        exp_evt;
   } vec_t;

   vec_t tbl[$];

   arrow_key_decoder #(.PREFIX_TIMEOUT(16)) dut (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .key       (key),
      .held      (held),
      .key_event (key_event)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge pclk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic add(input string nm, input int unsigned nb, input logic [31:0] bytes,
                      input logic [3:0] k, input logic [3:0] h, input logic e);
      vec_t v;
      v.name = nm; v.nb = nb; v.bytes = bytes;
      v.exp_key = k; v.exp_held = h; v.exp_evt = e;
      tbl.push_back(v);
   endtask

   task automatic check_state(input string nm, input logic [3:0] k, input logic [3:0] h,
                              input logic e);
      chk({nm, " key"}, key, k);
      chk({nm, " held"}, held, h);
      chk({nm, " event"}, {3'b000, key_event}, {3'b000, e});
   endtask

   initial begin
      logic [31:0] bs;
      n_cmp = 0;
      n_err = 0;

      // bytes are sent from the most significant byte down, nb of them
      add("make_up",        2, 32'hE075_0000, 4'b0001, 4'b0001, 1'b1);
      add("break_up",       3, 32'hE0F0_7500, 4'b0000, 4'b0000, 1'b1);
      add("make_up2",       2, 32'hE075_0000, 4'b0001, 4'b0001, 1'b1);
      add("make_left",      2, 32'hE06B_0000, 4'b0100, 4'b0101, 1'b1);
      add("break_left",     3, 32'hE0F0_6B00, 4'b0001, 4'b0001, 1'b1);
      add("break_up2",      3, 32'hE0F0_7500, 4'b0000, 4'b0000, 1'b1);
      add("make_down",      2, 32'hE072_0000, 4'b0010, 4'b0010, 1'b1);
      add("make_right",     2, 32'hE074_0000, 4'b1000, 4'b1010, 1'b1);
      add("make_up3",       2, 32'hE075_0000, 4'b0001, 4'b1011, 1'b1);
      add("brk_up_fallbk",  3, 32'hE0F0_7500, 4'b0010, 4'b1010, 1'b1);
      add("brk_not_held",   3, 32'hE0F0_7500, 4'b0010, 4'b1010, 1'b0);
      add("brk_not_cur",    3, 32'hE0F0_7400, 4'b0010, 4'b0010, 1'b0);
      add("make_right2",    2, 32'hE074_0000, 4'b1000, 4'b1010, 1'b1);
      for (int i = 0; i < 4; i++)
         add("typematic",   2, 32'hE074_0000, 4'b1000, 4'b1010, 1'b0);
      add("nonext_brk",     2, 32'hF074_0000, 4'b1000, 4'b1010, 1'b0);
      add("bat_idle",       1, 32'hAA00_0000, 4'b1000, 4'b1010, 1'b0);
      add("ack_in_ext",     2, 32'hE0FA_0000, 4'b1000, 4'b1010, 1'b0);
      add("double_e0",      3, 32'hE0E0_7200, 4'b0010, 4'b1010, 1'b1);
      add("double_f0",      4, 32'hE0F0_F072, 4'b1000, 4'b1000, 1'b1);
      add("brk_then_ext",   3, 32'hF0E0_7400, 4'b1000, 4'b1000, 1'b0);
      add("extbrk_e0",      4, 32'hE0F0_E072, 4'b0010, 4'b1010, 1'b1);
`ifdef WASD_EN
      add("w_make",         1, 32'h1D00_0000, 4'b0001, 4'b1011, 1'b1);
      add("w_break",        2, 32'hF01D_0000, 4'b0010, 4'b1010, 1'b1);
`else
      add("w_make",         1, 32'h1D00_0000, 4'b0010, 4'b1010, 1'b0);
      add("w_break",        2, 32'hF01D_0000, 4'b0010, 4'b1010, 1'b0);
`endif
      add("clr_down",       3, 32'hE0F0_7200, 4'b1000, 4'b1000, 1'b1);
      add("clr_right",      3, 32'hE0F0_7400, 4'b0000, 4'b0000, 1'b1);
`ifdef WASD_EN
      add("a_make",         1, 32'h1C00_0000, 4'b0100, 4'b0100, 1'b1);
      add("arrow_clr_a",    3, 32'hE0F0_6B00, 4'b0000, 4'b0000, 1'b1);
`else
      add("a_make",         1, 32'h1C00_0000, 4'b0000, 4'b0000, 1'b0);
      add("arrow_clr_a",    3, 32'hE0F0_6B00, 4'b0000, 4'b0000, 1'b0);
`endif

      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #12;
      check_state("in_reset", 4'b0000, 4'b0000, 1'b0);
      #10 rst_n = 1'b1;
      @(negedge pclk);
      idle(2);
      check_state("after_reset", 4'b0000, 4'b0000, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         bs = tbl[i].bytes;
         for (int j = 0; j < int'(tbl[i].nb); j++) begin
            send(bs[31:24]);
            bs = bs << 8;
         end
         check_state(tbl[i].name, tbl[i].exp_key, tbl[i].exp_held, tbl[i].exp_evt);
         idle(1);
         chk({tbl[i].name, " event_gone"}, {3'b000, key_event}, 4'b0000);
      end

      // reset mid-sequence clears state at once and drops the pending E0
      send(8'hE0); send(8'h75);
      check_state("pre_rst", 4'b0001, 4'b0001, 1'b1);
      send(8'hE0);
      #2 rst_n = 1'b0;
      #1 check_state("async_rst", 4'b0000, 4'b0000, 1'b0);
      @(negedge pclk);
      rst_n = 1'b1;
      idle(1);
      send(8'h75);
      check_state("lone_75", 4'b0000, 4'b0000, 1'b0);

      // full timeout discards the prefix
      send(8'hE0);
      idle(16);
      send(8'h75);
      check_state("timeout16", 4'b0000, 4'b0000, 1'b0);

      // byte on the final cycle wins over the timeout
      send(8'hE0);
      idle(15);
      send(8'h75);
      check_state("gap15", 4'b0001, 4'b0001, 1'b1);

      // timeout leaves held/key alone
      send(8'hE0);
      idle(20);
      send(8'h72);
      check_state("timeout_keep", 4'b0001, 4'b0001, 1'b0);

      // long break-prefix timeout: later 75 is ignored, UP stays held
      send(8'hE0); send(8'hF0);
      idle(40);
      send(8'h75);
      check_state("extbrk_timeout", 4'b0001, 4'b0001, 1'b0);

      send(8'hE0); send(8'hF0); send(8'h75);
      check_state("final_clear", 4'b0000, 4'b0000, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/arrow_key_decoder.md
Name: arrow_key_decoder

Overview:
- Upstream stage of the car controller.
- Consumes the byte stream from the PS/2 receiver, which delivers one byte per strobe using scan-code set 2.
- Tracks make/break state of the four arrow keys.
- Drives the controller's 4-bit one-hot key input with the most recently pressed, still-held key.
- Runs in the pclk domain (65 MHz pixel clock).

Parameters:
PREFIX_TIMEOUT, 650000, pclk cycles a pending E0/F0 prefix may wait for its next byte before being discarded (10 ms at 65 MHz).

Ports:
pclk  input  1  system/pixel clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  received scan-code byte, valid when rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte
key  output  4  one-hot active key: bit0 UP, bit1 DOWN, bit2 LEFT, bit3 RIGHT; 0 = none
held  output  4  bitmap of all currently held arrow keys, same bit order
key_event  output  1  one-cycle pulse when key changes value

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, key=0, held=0, key_event=0, timeout counter=0.
- Reset mid-sequence discards any pending prefix.
- Codes, all extended with the E0 prefix: UP=75, DOWN=72, LEFT=6B, RIGHT=74.
  - Make: E0 xx.
  - Break: E0 F0 xx.
- State machine; advances only on rx_valid=1:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte ignored, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; arrow code -> make(key) and go to IDLE; any other code -> IDLE, no effect.
  - EXT_BRK: E0 -> EXT; F0 -> stay; arrow code -> break(key) and go to IDLE; any other code -> IDLE, no effect.
  - BRK (non-extended break): E0 -> EXT; F0 -> stay; any other byte -> IDLE with no effect. This swallows non-arrow breaks.
- make(k):
  - held[k] set.
  - key becomes one-hot k, even if k was already held (typematic repeat).
- break(k):
  - held[k] cleared.
  - If key==k, key falls back to the highest-priority remaining held key (UP > DOWN > LEFT > RIGHT), or 0 if none remain.
  - If key!=k, key is unchanged.
- Break of a key not held: no change, no event.
- Latency:
  - held and key update on the same rising edge that samples the completing byte with rx_valid=1.
  - key_event is high for exactly the following cycle, and only if the key value changed.
  - Repeat make of the current key produces no event.
- key is always one-hot or zero. It is never multi-bit, which the controller relies on.
- Prefix timeout:
  - The counter clears on every rx_valid and increments each cycle while state != IDLE.
  - When the counter reaches PREFIX_TIMEOUT-1 with no rx_valid, state returns to IDLE and the counter clears.
  - held and key are unaffected by a timeout.
- Counter width: $clog2(PREFIX_TIMEOUT+1) bits; saturates and never wraps.
- rx_valid on the timeout cycle: the byte wins; it is processed in the current state and the timeout is ignored.
- 0xAA (BAT pass) or 0xFA (ACK) in any state: treated as "other byte" per the transition rules above.

Optional Feature:
WASD_EN
- Defined:
  - Non-extended makes in IDLE also drive the four keys: W=1D -> UP, S=1B -> DOWN, A=1C -> LEFT, D=23 -> RIGHT.
  - Breaks F0 xx in BRK clear them.
  - A letter and its matching arrow share one held bit. Releasing either source clears the bit.
- Undefined: non-extended bytes never affect held or key, exactly as specified above.

Test Plan:
- Reset: rst_n low mid-sequence (after E0) -> key=0, held=0 immediately; next byte 75 alone -> no change.
- E0 75 -> held=0001, key=0001, key_event pulse 1 cycle; E0 F0 75 -> held=0000, key=0000, one more pulse.
- E0 75 then E0 6B -> key=0100, held=0101; E0 F0 6B -> key=0001; E0 F0 75 -> key=0000, held=0000.
- E0 72, E0 74, E0 75, then break UP -> key falls to 0010 (DOWN beats RIGHT), held=1010.
- Typematic: E0 74 repeated 5 times -> key=1000 stays; exactly one key_event.
- Timeout: E0, then idle PREFIX_TIMEOUT cycles (TB override 16), then 75 -> no effect, key=0. With a 15-cycle gap -> UP registers.
- WASD_EN build: 1D -> key=0001; F0 1D -> key=0000. Same stimulus without the macro -> no change.
